// File: rtl/hazard_fwd_unit.sv
// Execute-stage operand forwarding, decode load-use detection and bubble FSM.
// Define FWD_WB_HOLD_EN to add the held-writeback (X) stage and allow LOAD_LAT=2.
module hazard_fwd_unit #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*AW-1:0]   rsD,
  input  logic                 validD,
  input  logic                 flushD,
  input  logic [NSRC*AW-1:0]   rsE,
  input  logic [NSRC*XLEN-1:0] sourceE,
  input  logic [AW-1:0]        rdE,
  input  logic                 reg_writeE,
  input  logic [2:0]           mem_loadE,
  input  logic [AW-1:0]        rdM,
  input  logic [XLEN-1:0]      resultM,
  input  logic                 reg_writeM,
  input  logic [2:0]           mem_loadM,
  input  logic [AW-1:0]        rdW,
  input  logic [XLEN-1:0]      distW,
  input  logic                 reg_writeW,
  output logic [NSRC*XLEN-1:0] reg_dataE,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 flushE
);

  typedef enum logic {IDLE, STALL} stateT;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);

  stateT       stateQ, stateD;
  logic [1:0]  cntQ, cntD;
  logic        rsMatch, haz, stallReq;
  logic [AW-1:0] rsCur;

`ifdef FWD_WB_HOLD_EN
  if (LOAD_LAT < 1 || LOAD_LAT > 2) begin : gBadLat
    $error("hazard_fwd_unit: LOAD_LAT must be 1 or 2");
  end

  logic            validX;
  logic [AW-1:0]   rdX;
  logic [XLEN-1:0] distX;

  // X keeps last cycle's writeback visible; deliberately not stall-gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validX <= 1'b0;
      rdX    <= '0;
      distX  <= '0;
    end else begin
      validX <= reg_writeW && (rdW != '0);
      rdX    <= rdW;
      distX  <= distW;
    end
  end
`else
  if (LOAD_LAT != 1) begin : gBadLat
    $error("hazard_fwd_unit: LOAD_LAT must be 1 without FWD_WB_HOLD_EN");
  end
`endif

  always_comb begin
    reg_dataE = '0;
    rsCur     = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      rsCur = rsE[i*AW +: AW];
      if (rsCur != '0 && rsCur == rdM && reg_writeM && mem_loadM == 3'b000)
        reg_dataE[i*XLEN +: XLEN] = resultM;
      else if (rsCur != '0 && rsCur == rdW && reg_writeW)
        reg_dataE[i*XLEN +: XLEN] = distW;
`ifdef FWD_WB_HOLD_EN
      else if (rsCur != '0 && rsCur == rdX && validX)
        reg_dataE[i*XLEN +: XLEN] = distX;
`endif
      else
        reg_dataE[i*XLEN +: XLEN] = sourceE[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    rsMatch = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (rsD[i*AW +: AW] != '0 && rsD[i*AW +: AW] == rdE) rsMatch = 1'b1;
    end
  end

  assign haz = validD && reg_writeE && (mem_loadE != 3'b000) && (rdE != '0) && rsMatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // The first bubble is issued from IDLE; STALL only covers bubbles beyond it.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    stallReq = 1'b0;
    case (stateQ)
      IDLE: begin
        if (haz && !flushD) begin
          stallReq = 1'b1;
          if (LOAD_LAT > 1) begin
            cntD   = CNT_INIT;
            stateD = STALL;
          end
        end
      end
      STALL: begin
        stallReq = !flushD;
        if (flushD || cntQ == '0) stateD = IDLE;
        else                      cntD   = cntQ - 2'd1;
      end
      default: stateD = IDLE;
    endcase
  end

  // Reset also masks the Mealy stall path while rst_n is low.
  assign stallF = rst_n && stallReq;
  assign stallD = rst_n && stallReq;
  assign flushE = rst_n && stallReq;

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised execute-stage hazard and forwarding unit for the RV32I 5-stage pipeline (F/D/E/M/W), replacing the purely combinational E-stage forwarding logic. It has three jobs:
- Select the operand for each of NSRC execute-stage source ports from M, W, an optional held-writeback stage (X) or the register file.
- Detect load-use hazards in decode.
- Run a small stall FSM that inserts LOAD_LAT bubbles, so memories with one or two cycles of load latency are supported.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREG, 32, architectural register count; AW = $clog2(NREG)
- NSRC, 2, number of source operand ports (port i occupies bits [i*W +: W])
- LOAD_LAT, 1, load-use bubble count, legal 1..2 (2 requires FWD_WB_HOLD_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rsD  in  NSRC*AW  decode-stage source register indices
- validD  in  1  decode holds a valid instruction
- flushD  in  1  branch/jump redirect; decode instruction is being killed
- rsE  in  NSRC*AW  execute-stage source register indices
- sourceE  in  NSRC*XLEN  register-file read data for rsE
- rdE  in  AW  execute-stage destination
- reg_writeE  in  1  execute instruction writes rdE
- mem_loadE  in  3  execute load type, 3'b000 = not a load
- rdM  in  AW, resultM  in  XLEN, reg_writeM  in  1, mem_loadM  in  3  memory-stage destination, ALU result, write enable, load type
- rdW  in  AW, distW  in  XLEN, reg_writeW  in  1  writeback destination, data, write enable
- reg_dataE  out  NSRC*XLEN  forwarded operands
- stallF  out  1  hold PC
- stallD  out  1  hold F/D register
- flushE  out  1  insert bubble into D/E register

## Operation
- Forwarding per port i, first match wins; rd == 0 never matches:
  1. M: rsE[i]==rdM, reg_writeM, mem_loadM==3'b000 -> resultM. A load in M is never forwarded from M.
  2. W: rsE[i]==rdW, reg_writeW -> distW.
  3. X (FWD_WB_HOLD_EN only): rsE[i]==rdX, validX -> distX.
  4. Otherwise sourceE[i].
- X stage: on each edge, validX <= reg_writeW && rdW!=0; rdX <= rdW; distX <= distW. X captures every cycle and is not gated by stalls.
- Hazard: haz = validD && reg_writeE && mem_loadE!=0 && rdE!=0 && (any rsD[i]==rdE). Ports whose index is 0 never match.
- FSM states:
  - IDLE: if haz && !flushD, drive stall outputs this cycle. If LOAD_LAT>1, load cnt <= LOAD_LAT-2 and go to STALL; otherwise stay in IDLE (the E bubble clears haz next cycle).
  - STALL: drive stall outputs. If flushD, go to IDLE. Else if cnt==0, go to IDLE. Else cnt <= cnt-1.
- Stall outputs: stallF = stallD = flushE = 1 together, Mealy. They are forced to 0 in any cycle with flushD=1.
- Total bubbles per hazard = LOAD_LAT. Afterwards the load data reaches E via W (LOAD_LAT=1) or X (LOAD_LAT=2).

## Timing
- Reset (asynchronous, rst_n low): state=IDLE, cnt=0, validX=0, rdX=0, distX=0. stallF/stallD/flushE are 0 while reset is asserted. reg_dataE stays combinational from its inputs.
- Forwarding latency is 0 cycles (combinational). The X stage adds 1 cycle of registered delay after W.
- The hazard raises stalls in the same cycle it is detected. They stay high for exactly LOAD_LAT cycles unless flushD or reset arrives first.
- flushD together with haz: no stall, and the FSM stays in IDLE.
- Reset asserted mid-STALL: stalls drop immediately, and the FSM is in IDLE after reset is released.
- Simultaneous M and W match on the same register: M wins (youngest value).

## Configuration
- FWD_WB_HOLD_EN defined: the X-stage registers and priority-3 forwarding are compiled in, and LOAD_LAT=2 is legal.
- Undefined: the X stage is absent and forwarding stops at W; the register file is write-through. LOAD_LAT must be 1, and any other value triggers an elaboration-time $error.

## Test plan
- Priority: rsE[0]=5, rdM=5 (resultM=0x11), rdW=5 (distW=0x22), both writing -> reg_dataE[0]=0x11. With reg_writeM=0 -> 0x22.
- x0 and loads: rdM=0, reg_writeM=1, sourceE[1]=0xAB, rsE[1]=0 -> 0xAB. rdM=7 with mem_loadM=3'b010, rsE[0]=7, no W match -> sourceE[0].
- Load-use, LOAD_LAT=1: lw x7 in E, rsD[1]=7, validD=1 -> stallF/stallD/flushE high for exactly 1 cycle. Two cycles later, with the load in W (distW=0x1234), rsE[1]=7 -> 0x1234.
- LOAD_LAT=2 with FWD_WB_HOLD_EN: same hazard -> 2 stall cycles. The dependent instruction in E gets distX=0xDEADBEEF captured from the prior W.
- flushD asserted in the first STALL cycle (LOAD_LAT=2) -> stalls are 0 that cycle, and the FSM is in IDLE next cycle with no further stall.
- rst_n pulsed low during STALL -> stalls 0 immediately, validX=0. After release, no stall until a new hazard.
